// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, instruction
// class and memory sub-op codes, ALU-op classes and PC source select.
package ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6,
    StError  = 3'd7
  } ctrl_state_e;

  // instr[8:7] instruction class
  localparam logic [1:0] ClsR   = 2'b00;
  localparam logic [1:0] ClsI   = 2'b01;
  localparam logic [1:0] ClsBr  = 2'b10;
  localparam logic [1:0] ClsSys = 2'b11;

  // instr[6:5] sub-op for the system class
  localparam logic [1:0] SubLoad  = 2'b00;
  localparam logic [1:0] SubStore = 2'b01;
  localparam logic [1:0] SubHalt  = 2'b10;
  localparam logic [1:0] SubNop   = 2'b11;

  // ALU-op class handed to the ALU decoder
  localparam logic [1:0] AluR    = 2'b00;
  localparam logic [1:0] AluI    = 2'b01;
  localparam logic [1:0] AluBr   = 2'b10;
  localparam logic [1:0] AluPass = 2'b11;

  // PC source select
  localparam logic PcSrcSeq = 1'b0;
  localparam logic PcSrcTgt = 1'b1;

endpackage

// File: rtl/multicycle_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count up on i_inc, hold at all-ones instead of wrapping.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback,
// runs the data-memory req/ack handshake with a timeout, and keeps
// saturating busy-cycle and retired-instruction counters.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [8:0]       i_instr,
  input  logic             i_zero,
  input  logic             i_mem_ack,
  output logic [1:0]       o_alu_op,
  output logic             o_pc_we,
  output logic             o_pc_src,
  output logic             o_ir_we,
  output logic             o_reg_we,
  output logic             o_wb_sel,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [CNT_W-1:0] o_retired_count
);

  localparam int unsigned WaitW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  ctrl_state_e      r_state;
  logic [WaitW-1:0] r_wait;

  logic [1:0] w_cls;
  logic [1:0] w_sub;
  logic       w_is_sys;
  logic       w_is_halt;
  logic       w_is_nop;
  logic       w_is_load;
  logic       w_taken;
  logic       w_timeout;
  logic       w_start_clr;
  logic       w_retire;

  assign w_cls     = i_instr[8:7];
  assign w_sub     = i_instr[6:5];
  assign w_is_sys  = (w_cls == ClsSys);
  assign w_is_halt = w_is_sys && (w_sub == SubHalt);
  assign w_is_nop  = w_is_sys && (w_sub == SubNop);
  assign w_is_load = w_is_sys && (w_sub == SubLoad);
  // instr[6] = 1 is an unconditional jump, otherwise beq on zero
  assign w_taken   = i_instr[6] | i_zero;
  // Limit reached on this MEM cycle; ACK_TIMEOUT = 0 disables the check
  assign w_timeout = (ACK_TIMEOUT != 0) && ((32'(r_wait) + 32'd1) == ACK_TIMEOUT);

  // State register and MEM wait counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_wait  <= '0;
    end else begin
      unique case (r_state)
        StIdle:   if (i_start) r_state <= StFetch;
        StFetch:  r_state <= StDecode;
        StDecode: begin
          if (w_is_halt)     r_state <= StHalt;
          else if (w_is_nop) r_state <= StFetch;
          else               r_state <= StExec;
        end
        StExec: begin
          r_wait <= '0;
          unique case (w_cls)
            ClsBr:   r_state <= StFetch;
            ClsSys:  r_state <= StMem;
            default: r_state <= StWb;
          endcase
        end
        StMem: begin
          // ack wins over a timeout landing in the same cycle
          if (i_mem_ack)      r_state <= w_is_load ? StWb : StFetch;
          else if (w_timeout) r_state <= StError;
          else                r_wait  <= r_wait + 1'b1;
        end
        StWb:    r_state <= StFetch;
        StHalt:  if (i_start) r_state <= StFetch;
        StError: r_state <= StError;
        default: r_state <= StError;
      endcase
    end
  end

  // Output decode from state and IR; pc_src/pc_we also see zero and mem_ack.
  always_comb begin
    o_alu_op  = AluPass;
    o_pc_we   = 1'b0;
    o_pc_src  = PcSrcSeq;
    o_ir_we   = 1'b0;
    o_reg_we  = 1'b0;
    o_wb_sel  = 1'b0;
    o_mem_req = 1'b0;
    o_mem_we  = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    o_err     = 1'b0;
    unique case (r_state)
      StFetch: begin
        o_busy  = 1'b1;
        o_ir_we = 1'b1;
      end
      StDecode: begin
        o_busy  = 1'b1;
        o_pc_we = w_is_nop;
      end
      StExec: begin
        o_busy = 1'b1;
        if (!w_is_sys) o_alu_op = w_cls;
        if (w_cls == ClsBr) begin
          o_pc_we  = 1'b1;
          o_pc_src = w_taken ? PcSrcTgt : PcSrcSeq;
        end
      end
      StMem: begin
        o_busy    = 1'b1;
        o_mem_req = 1'b1;
        o_mem_we  = (w_sub == SubStore);
        o_pc_we   = i_mem_ack && !w_is_load;
      end
      StWb: begin
        o_busy   = 1'b1;
        o_reg_we = 1'b1;
        o_pc_we  = 1'b1;
        o_wb_sel = w_is_load;
      end
      StHalt:  o_done = 1'b1;
      StError: o_err  = 1'b1;
      default: ;
    endcase
  end

  assign w_start_clr = i_start && ((r_state == StIdle) || (r_state == StHalt));
  assign w_retire    = o_pc_we || ((r_state == StDecode) && w_is_halt);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_start_clr),
    .i_inc   (o_busy),
    .o_count (o_cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_retired_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_start_clr),
    .i_inc   (w_retire),
    .o_count (o_retired_count)
  );

endmodule
